// File: rtl/if_id_queue.sv
// IF/ID instruction queue: small FIFO of {pc, instr, pc+4} between fetch and decode.
// Optional fetch-stall counter enabled by macro IF_ID_QUEUE_STALL_STATS_EN.
module if_id_queue #(
   parameter  int DEPTH  = 4,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_pc,
   input  logic [31:0]       in_instr,
   input  logic [31:0]       in_pc_plus4,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_pc,
   output logic [31:0]       out_instr,
   output logic [31:0]       out_pc_plus4,
   output logic [ADDR_W:0]   count,
   output logic [31:0]       stall_count
);

   localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

   logic [95:0]       r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;

   logic        w_in_ready;
   logic        w_out_valid;
   logic        w_push;
   logic        w_pop;
   logic [95:0] w_head;

   assign w_in_ready  = (r_count != FULL);
   assign w_out_valid = (r_count != '0);
   assign w_push      = in_valid && w_in_ready && !flush;
   assign w_pop       = w_out_valid && out_ready && !flush;
   assign w_head      = r_mem[r_rd_ptr];

   assign in_ready     = w_in_ready;
   assign out_valid    = w_out_valid;
   assign out_pc       = w_out_valid ? w_head[95:64] : 32'h0;
   assign out_instr    = w_out_valid ? w_head[63:32] : 32'h0;
   assign out_pc_plus4 = w_out_valid ? w_head[31:0]  : 32'h0;
   assign count        = r_count;

   // Storage write on push; contents are never reset since reads are masked when empty.
   always_ff @(posedge clk) begin
      if (reset && w_push) begin
         r_mem[r_wr_ptr] <= {in_pc, in_instr, in_pc_plus4};
      end
   end

   // Pointer and occupancy update; reset dominates flush, flush dominates push/pop.
   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
   end

`ifdef IF_ID_QUEUE_STALL_STATS_EN
   logic [31:0] r_stall_count;

   // Saturating count of cycles where fetch is blocked by a full queue.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_stall_count <= '0;
      end else if (in_valid && !w_in_ready && (r_stall_count != 32'hFFFF_FFFF)) begin
         r_stall_count <= r_stall_count + 32'd1;
      end
   end

   assign stall_count = r_stall_count;
`else
   assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue.
// Compares the DUT against a queue-based reference model.
module tb_if_id_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_instr;
   logic [31:0] in_pc_plus4;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [31:0] out_pc_plus4;
   logic [2:0]  count;
   logic [31:0] stall_count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [95:0] mq [$];
   longint      m_stall = 0;

   always #5 clk = ~clk;

   if_id_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk),
      .reset(reset),
      .flush(flush),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_pc(in_pc),
      .in_instr(in_instr),
      .in_pc_plus4(in_pc_plus4),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_pc(out_pc),
      .out_instr(out_instr),
      .out_pc_plus4(out_pc_plus4),
      .count(count),
      .stall_count(stall_count)
   );

   task automatic drive(input logic v, input logic [31:0] pc,
                        input logic [31:0] ins, input logic r,
                        input logic f);
      in_valid    = v;
      in_pc       = pc;
      in_instr    = ins;
      in_pc_plus4 = pc + 32'd4;
      out_ready   = r;
      flush       = f;
   endtask

   // Advance one clock, applying the queue rules to the model.
   task automatic step();
      bit full;
      bit pop;
      @(posedge clk);
      if (!reset) begin
         mq.delete();
         m_stall = 0;
      end else begin
         full = (mq.size() == DEPTH);
`ifdef IF_ID_QUEUE_STALL_STATS_EN
         if (in_valid && full && m_stall < 64'hFFFF_FFFF) m_stall++;
`endif
         if (flush) begin
            mq.delete();
         end else begin
            pop = (mq.size() > 0) && out_ready;
            if (pop) void'(mq.pop_front());
            if (in_valid && !full) mq.push_back({in_pc, in_instr, in_pc_plus4});
         end
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(0, 0, 0, 0, 0);
      step();
      step();
      reset = 1'b1;
      step();
      n_checks++;
      if (out_valid !== 1'b0 || out_instr !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_out valid=%b instr=%h required 0/0", out_valid, out_instr);
      end
      n_checks++;
      if (in_ready !== 1'b1 || count !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_ready in_ready=%b count=%0d required 1/0", in_ready, count);
      end
      n_checks++;
      if (stall_count !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_stall got=%0d required 0", stall_count);
      end
   endtask

   task automatic test_pass_through();
      drive(1, 32'h0, 32'h2008_0005, 1, 0);
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL pt_no_bypass out_valid=%b required 0", out_valid);
      end
      step();
      drive(0, 0, 0, 1, 0);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h2008_0005
          || out_pc_plus4 !== 32'h4 || count !== 3'd1) begin
         n_fail++;
         $display("FAIL pt_head v=%b pc=%h ins=%h p4=%h cnt=%0d required 1/0/20080005/4/1",
                  out_valid, out_pc, out_instr, out_pc_plus4, count);
      end
      step();
      n_checks++;
      if (count !== 3'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL pt_drain count=%0d valid=%b required 0/0", count, out_valid);
      end
   endtask

   task automatic test_fill_stall();
      logic [31:0] exp_stall;
`ifdef IF_ID_QUEUE_STALL_STATS_EN
      exp_stall = 32'd3;
`else
      exp_stall = 32'd0;
`endif
      for (int i = 0; i < 4; i++) begin
         drive(1, 32'(i * 4), 32'hA000_0000 + 32'(i), 0, 0);
         step();
      end
      n_checks++;
      if (count !== 3'd4 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_full count=%0d in_ready=%b required 4/0", count, in_ready);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h10, 32'hBBBB_BBBB, 0, 0);
         step();
      end
      n_checks++;
      if (count !== 3'd4 || stall_count !== exp_stall) begin
         n_fail++;
         $display("FAIL fill_stall count=%0d stall=%0d required 4/%0d",
                  count, stall_count, exp_stall);
      end
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 1, 0);
         n_checks++;
         if (out_valid !== 1'b1 || out_pc !== 32'(i * 4)
             || out_instr !== 32'hA000_0000 + 32'(i)) begin
            n_fail++;
            $display("FAIL fill_drain[%0d] v=%b pc=%h ins=%h required 1/%h/%h",
                     i, out_valid, out_pc, out_instr, i * 4, 32'hA000_0000 + 32'(i));
         end
         step();
      end
      n_checks++;
      if (count !== 3'd0) begin
         n_fail++;
         $display("FAIL fill_empty count=%0d required 0", count);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 2; i++) begin
         drive(1, 32'(i * 4), 32'(i), 0, 0);
         step();
      end
      for (int i = 0; i < 10; i++) begin
         drive(1, 32'((i + 2) * 4), 32'(i + 2), 1, 0);
         n_checks++;
         if (out_pc !== 32'(i * 4) || count !== 3'd2 || out_instr !== 32'(i)) begin
            n_fail++;
            $display("FAIL wrap[%0d] pc=%h ins=%h count=%0d required %h/%h/2",
                     i, out_pc, out_instr, count, i * 4, i);
         end
         step();
      end
      drive(0, 0, 0, 1, 0);
      step();
      step();
      n_checks++;
      if (count !== 3'd0) begin
         n_fail++;
         $display("FAIL wrap_drain count=%0d required 0", count);
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h100 + 32'(i * 4), 32'h1, 0, 0);
         step();
      end
      drive(1, 32'h40, 32'h2, 1, 1);
      step();
      drive(0, 0, 0, 0, 0);
      n_checks++;
      if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL flush_clear count=%0d valid=%b pc=%h required 0/0/0",
                  count, out_valid, out_pc);
      end
      drive(1, 32'h80, 32'h3, 0, 0);
      step();
      drive(0, 0, 0, 1, 0);
      n_checks++;
      if (out_pc !== 32'h80 || count !== 3'd1) begin
         n_fail++;
         $display("FAIL flush_next pc=%h count=%0d required 80/1", out_pc, count);
      end
      step();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 2; i++) begin
         drive(1, 32'h300 + 32'(i * 4), 32'h5, 0, 0);
         step();
      end
      reset = 1'b0;
      drive(1, 32'h200, 32'h6, 1, 1);
      step();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0);
      n_checks++;
      if (count !== 3'd0 || stall_count !== 32'h0 || out_valid !== 1'b0
          || out_pc !== 32'h0 || out_instr !== 32'h0 || out_pc_plus4 !== 32'h0
          || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid cnt=%0d stall=%0d v=%b pc=%h ins=%h p4=%h rdy=%b required all 0, rdy 1",
                  count, stall_count, out_valid, out_pc, out_instr, out_pc_plus4, in_ready);
      end
      drive(1, 32'h500, 32'h7, 0, 0);
      step();
      drive(0, 0, 0, 1, 0);
      n_checks++;
      if (out_pc !== 32'h500 || out_instr !== 32'h7) begin
         n_fail++;
         $display("FAIL reset_first pc=%h ins=%h required 500/7", out_pc, out_instr);
      end
      step();
   endtask

   task automatic test_random();
      logic [95:0] h;
      for (int c = 0; c < 600; c++) begin
         reset = ($urandom_range(0, 99) != 0);
         drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
               1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0));
         step();
         h = (mq.size() != 0) ? mq[0] : 96'h0;
         n_checks++;
         if (out_valid !== (mq.size() != 0) || count !== 3'(mq.size())
             || in_ready !== (mq.size() != DEPTH)) begin
            n_fail++;
            $display("FAIL rnd_ctl[%0d] v=%b cnt=%0d rdy=%b required size=%0d",
                     c, out_valid, count, in_ready, mq.size());
         end
         n_checks++;
         if ({out_pc, out_instr, out_pc_plus4} !== h) begin
            n_fail++;
            $display("FAIL rnd_data[%0d] got=%h required=%h",
                     c, {out_pc, out_instr, out_pc_plus4}, h);
         end
         n_checks++;
         if (stall_count !== 32'(m_stall)) begin
            n_fail++;
            $display("FAIL rnd_stall[%0d] got=%0d required=%0d", c, stall_count, m_stall);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, 0);
      test_reset();
      test_pass_through();
      test_fill_stall();
      test_wrap();
      test_flush();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction queue between the fetch stage and the decode stage of the single-issue MIPS pipeline.
- Buffers fetched triples {pc, instrucao, pc_incrementado} in a small FIFO and presents them to decode with a valid/ready handshake.
- Lets fetch run ahead while decode stalls; supports a flush when a branch or jump redirects the PC.

Parameters:
DEPTH, 4, number of queue entries; must be a power of two and at least 2
ADDR_W, $clog2(DEPTH), pointer width (derived, not to be overridden)

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising edge of clk
flush  input  1  discard all queued entries and any push in the same cycle
in_valid  input  1  fetch presents a valid instruction
in_ready  output  1  queue accepts a push this cycle
in_pc  input  32  PC of fetched instruction
in_instr  input  32  fetched instruction word
in_pc_plus4  input  32  in_pc + 4 from fetch
out_valid  output  1  head entry valid for decode
out_ready  input  1  decode consumes head this cycle
out_pc  output  32  head PC
out_instr  output  32  head instruction
out_pc_plus4  output  32  head PC+4
count  output  ADDR_W+1  number of occupied entries, 0..DEPTH
stall_count  output  32  fetch-stall cycle counter (see Optional Feature)

Behaviour:
- Push = in_valid && in_ready && !flush. Pop = out_valid && out_ready && !flush.
- in_ready = (count != DEPTH). It is combinational from registered count only, with no dependence on out_ready. When full, a same-cycle pop does not enable a push.
- out_valid = (count != 0). out_* are read combinationally from storage[rd_ptr], so an entry pushed at edge N is visible after edge N, giving 1-cycle latency. There is no fall-through bypass.
- When out_valid = 0: out_pc, out_instr and out_pc_plus4 are forced to 32'h0. out_instr = 0 is a NOP.
- Push writes storage[wr_ptr] and increments wr_ptr. Pop increments rd_ptr. Pointers are ADDR_W bits and wrap modulo DEPTH.
- count next value:
  - +1 on push only
  - -1 on pop only
  - unchanged on simultaneous push and pop (legal whenever 0 < count < DEPTH)
- A push when count = 0 together with out_ready = 1 is not a pop. The entry appears the next cycle.
- Flush (flush = 1, reset inactive):
  - next cycle: wr_ptr = rd_ptr = 0, count = 0
  - the same-cycle push is dropped
  - the same-cycle pop does not count as consumed
  - storage contents are don't-care
- Reset (reset = 0 at a rising edge) has priority over flush and push/pop:
  - wr_ptr, rd_ptr and count go to 0
  - out_valid = 0, out_* = 0
  - in_ready = 1
  - stall_count = 0
- Reset asserted mid-stream discards all entries. The first push after reset deasserts lands at index 0.
- Data fields pass through unmodified. The queue does not check in_pc_plus4 == in_pc + 4.
- No X propagation: storage is not reset, but out_* are masked to 0 when empty.

Optional Feature:
- Macro IF_ID_QUEUE_STALL_STATS_EN.
- Defined:
  - stall_count increments by 1 on every cycle with in_valid = 1 and in_ready = 0, with reset inactive.
  - It saturates at 32'hFFFFFFFF.
  - It is cleared only by reset; flush does not clear it.
- Undefined: stall_count is tied to 32'h0 and no counter register is synthesized.
- The port is present in both builds.

Test Plan:
- Reset then idle: reset = 0 for 2 cycles, then 1 → out_valid = 0, out_instr = 0, in_ready = 1, count = 0.
- Single pass-through: push pc = 0x00000000, instr = 0x20080005, pc_plus4 = 0x4 at edge N, out_ready = 1 → out_valid = 1 with those values after edge N only; count returns to 0 after edge N+1.
- Fill and stall (DEPTH = 4), with out_ready = 0:
  - push pcs 0x0, 0x4, 0x8, 0xC → count = 4, in_ready = 0
  - hold in_valid with pc 0x10 for 3 cycles → no push; stall_count = 3 with the macro defined, 0 without
  - drain → outputs 0x0, 0x4, 0x8, 0xC in order
- Wrap-around with concurrency: keep count at 2 with simultaneous push/pop for 10 cycles using pcs 0x0..0x24 → output order is strictly ascending, count stays 2, and pointers wrap without loss.
- Flush with push: count = 3, assert flush with in_valid = 1 and pc = 0x40 → next cycle count = 0, out_valid = 0; a following push of pc 0x80 is the first output.
- Reset mid-operation: count = 2, assert reset = 0 together with flush = 1 and in_valid = 1 → count = 0, stall_count = 0, out_* = 0 next cycle.
